// File: rtl/cv32e40p_hwloop_perm_pkg.sv
// Shared types and constants for the hardware-loop permutation scheduler.
package cv32e40p_hwloop_perm_pkg;

    localparam int unsigned NUM_INPUT    = 4;
    localparam int unsigned INPUT_WIDTH  = 2;
    localparam int unsigned NUM_CTRL_BIT = 5;
    localparam int unsigned CNT_WIDTH    = 32;
    localparam int unsigned LFSR_WIDTH   = 16;

    localparam logic [LFSR_WIDTH-1:0] LFSR_MASK         = 16'hB400;
    localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One Galois step, shifting right and folding the mask in on a set LSB.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : {LFSR_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/cv32e40p_hwloop_perm_scheduler_if.sv
// Permuter request/response and iteration handshake bundle.
interface cv32e40p_hwloop_perm_scheduler_if;
    import cv32e40p_hwloop_perm_pkg::*;

    logic                              perm_next_o;
    logic [NUM_CTRL_BIT-1:0]           perm_random_o;
    logic [NUM_INPUT*INPUT_WIDTH-1:0]  perm_index_i;
    logic                              iter_valid_o;
    logic [CNT_WIDTH-1:0]              iter_o;
    logic                              iter_ready_i;

    modport master (
        output perm_next_o, perm_random_o, iter_valid_o, iter_o,
        input  perm_index_i, iter_ready_i
    );

    modport slave (
        input  perm_next_o, perm_random_o, iter_valid_o, iter_o,
        output perm_index_i, iter_ready_i
    );

endinterface

// File: rtl/cv32e40p_hwloop_perm_lfsr.sv
// 16-bit Galois LFSR supplying random control bits; a zero seed loads the default.
module cv32e40p_hwloop_perm_lfsr
    import cv32e40p_hwloop_perm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  step,
    output logic [LFSR_WIDTH-1:0] state
);

    logic [LFSR_WIDTH-1:0] lfsr_d, lfsr_q;

    // Load has priority over step; otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/cv32e40p_hwloop_perm_scheduler.sv
// Walks count_i iterations in blocks of NUM_INPUT, requesting a permutation per
// block and issuing in-range iteration numbers in permuted order.
// Optional feature: CV32E40P_HWLOOP_PERM_LFSR_EN enables the LFSR-driven
// random control bits; without it perm_random_o is tied to zero.
module cv32e40p_hwloop_perm_scheduler
    import cv32e40p_hwloop_perm_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start_i,
    input  logic [CNT_WIDTH-1:0]                 count_i,
    input  logic [LFSR_WIDTH-1:0]                seed_i,
    input  logic                                 abort_i,
    cv32e40p_hwloop_perm_scheduler_if.master     bus,
    output logic                                 busy_o,
    output logic                                 done_o
);

    state_e                 state_d, state_q;
    logic [CNT_WIDTH-1:0]   count_d, count_q;
    logic [CNT_WIDTH-1:0]   base_d, base_q;
    logic [INPUT_WIDTH-1:0] slot_d, slot_q;

    logic [INPUT_WIDTH-1:0] slot_idx;
    logic [CNT_WIDTH-1:0]   idx;
    logic [CNT_WIDTH-1:0]   rem;
    logic                   in_range;
    logic                   last_slot;
    logic                   rem_last;
    logic                   lfsr_load;
    logic                   lfsr_step_en;

    // Current slot decode; base < count whenever ISSUE is active, so rem never wraps.
    assign slot_idx  = bus.perm_index_i[INPUT_WIDTH*32'(slot_q) +: INPUT_WIDTH];
    assign idx       = CNT_WIDTH'(slot_idx);
    assign rem       = count_q - base_q;
    assign in_range  = (idx < rem);
    assign last_slot = (slot_q == INPUT_WIDTH'(NUM_INPUT - 1));
    assign rem_last  = (rem <= CNT_WIDTH'(NUM_INPUT));

    // Next-state and counter update.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        base_d       = base_q;
        slot_d       = slot_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    count_d   = count_i;
                    base_d    = '0;
                    lfsr_load = 1'b1;
                    state_d   = (count_i == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                lfsr_step_en = 1'b1;
                slot_d       = '0;
                state_d      = ISSUE;
            end
            ISSUE: begin
                if (!in_range || bus.iter_ready_i) begin
                    if (last_slot) begin
                        if (rem_last) begin
                            state_d = DONE;
                        end else begin
                            base_d  = base_q + CNT_WIDTH'(NUM_INPUT);
                            state_d = REQ;
                        end
                    end else begin
                        slot_d = slot_q + INPUT_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            base_q  <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            base_q  <= base_d;
            slot_q  <= slot_d;
        end
    end

    // Outputs decoded from registered state and the stable permuter index.
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign bus.perm_next_o  = (state_q == REQ);
    assign bus.iter_valid_o = (state_q == ISSUE) && in_range;
    assign bus.iter_o       = bus.iter_valid_o ? (base_q + idx) : '0;

`ifdef CV32E40P_HWLOOP_PERM_LFSR_EN
    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic                  unused_lfsr_hi;

    cv32e40p_hwloop_perm_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed_i),
        .step  (lfsr_step_en),
        .state (lfsr_state)
    );

    assign bus.perm_random_o = (state_q == REQ) ? lfsr_state[NUM_CTRL_BIT-1:0] : '0;
    assign unused_lfsr_hi    = ^lfsr_state[LFSR_WIDTH-1:NUM_CTRL_BIT];
`else
    logic unused_lfsr;

    assign bus.perm_random_o = '0;
    assign unused_lfsr       = ^{lfsr_load, lfsr_step_en, seed_i};
`endif

endmodule

// File: tb/tb_cv32e40p_hwloop_perm_scheduler.sv
// Self-checking bench: the bench plays the permuter and the consumer, and
// predicts the issued iteration stream from the permutations it hands out.
module tb_cv32e40p_hwloop_perm_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] count_i = '0;
    logic [15:0] seed_i = '0;
    logic        busy_o;
    logic        done_o;

    cv32e40p_hwloop_perm_scheduler_if bus();

    cv32e40p_hwloop_perm_scheduler dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .count_i (count_i),
        .seed_i  (seed_i),
        .abort_i (abort_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    longint      cur_count;
    int          block_cnt, perm_cnt, done_cnt, acc_cnt, cyc, done_cyc;
    int          first_random;
    int          ready_pct = 100;
    int          stall_at = -1;
    int          stall_left = 0;
    int          abort_at = -1;
    int          busy_start_at = -1;
    bit          aborted;
    bit          fixed_perm;
    bit          hold_pending;
    logic [31:0] hold_val;
    logic [15:0] m_lfsr = 16'hACE1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference Galois step: divide by two, xor in the tap mask when a one falls out.
    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        logic [15:0] r;
        r = 16'(v / 16'd2);
        if (v % 16'd2 == 16'd1) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic start_loop(input logic [31:0] cnt, input logic [15:0] seed);
        start_i      = 1'b1;
        count_i      = cnt;
        seed_i       = seed;
        cur_count    = longint'(cnt);
        block_cnt    = 0;
        perm_cnt     = 0;
        done_cnt     = 0;
        acc_cnt      = 0;
        cyc          = 0;
        done_cyc     = -1;
        first_random = -1;
        aborted      = 1'b0;
        hold_pending = 1'b0;
        exp_q.delete();
        m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    endtask

    // One clock: observe at the falling edge, act as permuter and consumer.
    task automatic step();
        int          p[4];
        int          j, t;
        logic [7:0]  pk;
        logic [31:0] exp_rand;
        longint      rem;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        cyc++;
        if (cyc == busy_start_at) begin
            start_i = 1'b1;
            count_i = 32'd1;
        end
        if (hold_pending) begin
            check("hold_valid", 32'(bus.iter_valid_o), 32'd1);
            check("hold_iter", bus.iter_o, hold_val);
            hold_pending = 1'b0;
        end
        if (bus.perm_next_o) begin
`ifdef CV32E40P_HWLOOP_PERM_LFSR_EN
            exp_rand = 32'(m_lfsr[4:0]);
            m_lfsr   = ref_lfsr(m_lfsr);
`else
            exp_rand = 32'd0;
`endif
            if (perm_cnt == 0) first_random = int'(bus.perm_random_o);
            check("perm_random", 32'(bus.perm_random_o), exp_rand);
            if (fixed_perm) begin
                p = '{2, 0, 3, 1};
            end else begin
                p = '{0, 1, 2, 3};
                for (int i = 3; i > 0; i--) begin
                    j = int'($urandom_range(i, 0));
                    t = p[i]; p[i] = p[j]; p[j] = t;
                end
            end
            rem = cur_count - 64'(4 * block_cnt);
            for (int s = 0; s < 4; s++) begin
                pk[s*2 +: 2] = 2'(p[s]);
                if (longint'(p[s]) < rem) exp_q.push_back(32'(4 * block_cnt + p[s]));
            end
            bus.perm_index_i = pk;
            block_cnt++;
            perm_cnt++;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall_left > 0 && acc_cnt == stall_at && bus.iter_valid_o) begin
            bus.iter_ready_i = 1'b0;
            stall_left--;
        end else begin
            bus.iter_ready_i = ($urandom_range(99, 0) < 32'(ready_pct));
        end
        if (abort_at >= 0 && acc_cnt == abort_at && bus.iter_valid_o && bus.iter_ready_i) begin
            abort_i  = 1'b1;
            abort_at = -1;
            aborted  = 1'b1;
        end
        if (bus.iter_valid_o && bus.iter_ready_i) begin
            check("iter_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("iter", bus.iter_o, exp_q.pop_front());
            acc_cnt++;
        end else if (bus.iter_valid_o) begin
            hold_pending = 1'b1;
            hold_val     = bus.iter_o;
        end
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy_o && n < max_cyc);
        check("loop_bound", 32'(busy_o), 32'd0);
    endtask

    task automatic run_until_abort(input int max_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!aborted && n < max_cyc);
        check("abort_reached", 32'(aborted), 32'd1);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.iter_valid_o), 32'd0);
        check({tag, "_next"}, 32'(bus.perm_next_o), 32'd0);
        check({tag, "_iter"}, bus.iter_o, 32'd0);
        check({tag, "_random"}, 32'(bus.perm_random_o), 32'd0);
    endtask

    initial begin
        logic [31:0] cnt;
        bus.perm_index_i = '0;
        bus.iter_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // count 6, fixed permutation {2,0,3,1}, full throughput
        fixed_perm = 1'b1;
        ready_pct  = 100;
        start_loop(32'd6, 16'h1234);
        run_until_idle(100);
        check("t6_done_cyc", 32'(done_cyc), 32'd11);
        check("t6_idle_cyc", 32'(cyc), 32'd12);
        check("t6_perms", 32'(perm_cnt), 32'd2);
        check("t6_dones", 32'(done_cnt), 32'd1);
        check("t6_accepted", 32'(acc_cnt), 32'd6);
        check("t6_leftover", 32'(exp_q.size()), 32'd0);

        // count 0: done at cycle 1, nothing issued
        start_loop(32'd0, 16'h0);
        run_until_idle(10);
        check("t0_done_cyc", 32'(done_cyc), 32'd1);
        check("t0_perms", 32'(perm_cnt), 32'd0);
        check("t0_accepted", 32'(acc_cnt), 32'd0);
        check("t0_idle_cyc", 32'(cyc), 32'd2);

        // count 4, consumer stalls three cycles on slot 1
        fixed_perm = 1'b0;
        stall_at   = 1;
        stall_left = 3;
        start_loop(32'd4, 16'h5A5A);
        run_until_idle(50);
        check("stall_used", 32'(stall_left), 32'd0);
        check("stall_done_cyc", 32'(done_cyc), 32'd9);
        check("stall_perms", 32'(perm_cnt), 32'd1);
        check("stall_accepted", 32'(acc_cnt), 32'd4);
        stall_at = -1;

        // Seed 0 and seed 1 both give first control bits 5'h01
        ready_pct = 60;
        start_loop(32'd9, 16'h0000);
        run_until_idle(200);
`ifdef CV32E40P_HWLOOP_PERM_LFSR_EN
        check("seed0_first", 32'(first_random), 32'h01);
`else
        check("seed0_first", 32'(first_random), 32'h00);
`endif
        check("seed0_perms", 32'(perm_cnt), 32'd3);
        start_loop(32'd9, 16'h0001);
        run_until_idle(200);
`ifdef CV32E40P_HWLOOP_PERM_LFSR_EN
        check("seed1_first", 32'(first_random), 32'h01);
`else
        check("seed1_first", 32'(first_random), 32'h00);
`endif
        check("seed1_accepted", 32'(acc_cnt), 32'd9);

        // count 8, abort in block 2 slot 1 with a simultaneous transfer
        ready_pct = 100;
        abort_at  = 5;
        start_loop(32'd8, 16'hBEEF);
        run_until_abort(40);
        step();
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_valid", 32'(bus.iter_valid_o), 32'd0);
        check("abort_accepted", 32'(acc_cnt), 32'd6);
        repeat (3) step();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_perms", 32'(perm_cnt), 32'd2);
        start_loop(32'd3, 16'h0007);
        run_until_idle(50);
        check("restart_accepted", 32'(acc_cnt), 32'd3);
        check("restart_done", 32'(done_cnt), 32'd1);

        // Maximum count: two full blocks, then abort inside the third
        abort_at = 9;
        start_loop(32'hFFFF_FFFF, 16'h0003);
        run_until_abort(60);
        step();
        check("max_busy", 32'(busy_o), 32'd0);
        check("max_perms", 32'(perm_cnt), 32'd3);
        check("max_accepted", 32'(acc_cnt), 32'd10);
        check("max_no_done", 32'(done_cnt), 32'd0);

        // start_i while busy is ignored
        busy_start_at = 3;
        start_loop(32'd8, 16'h0009);
        run_until_idle(60);
        busy_start_at = -1;
        check("busy_start_accepted", 32'(acc_cnt), 32'd8);
        check("busy_start_perms", 32'(perm_cnt), 32'd2);
        check("busy_start_done", 32'(done_cnt), 32'd1);

        // Reset in the middle of ISSUE
        start_loop(32'd8, 16'h0002);
        repeat (3) step();
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        step();
        check_outputs_reset("midrst");
        rst_n = 1'b1;
        hold_pending = 1'b0;
        step();
        check("post_reset_idle", 32'(busy_o), 32'd0);

        // Random counts, seeds and consumer back-pressure
        ready_pct = 70;
        for (int k = 0; k < 6; k++) begin
            cnt = 32'($urandom_range(23, 1));
            start_loop(cnt, 16'($urandom));
            run_until_idle(400);
            check("rand_perms", 32'(perm_cnt), (cnt + 32'd3) / 32'd4);
            check("rand_accepted", 32'(acc_cnt), cnt);
            check("rand_done", 32'(done_cnt), 32'd1);
            check("rand_leftover", 32'(exp_q.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
